// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32I load/store unit in front of a synchronous block-RAM data
// memory. It steers byte/half/word lanes for stores, formats load data with
// sign/zero extension, and stalls the core while the BRAM read latency elapses.
// Misaligned or unsupported accesses are flagged and never reach the memory.
//
// Handshake: a request (req_read/req_write) is taken only in IDLE. A store
// completes in its issue cycle with stall low. A load raises stall from its
// issue cycle through every WAIT cycle; the formatted result is on rdata in
// the single DONE cycle that follows, with stall low. Requests still asserted
// in WAIT or DONE are ignored; the core drops them once it commits the load.
module dmem_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t             state;
    logic [2:0]         lat_cnt;
    logic [2:0]         ld_f3;
    logic [1:0]         ld_lane;
    logic [ADDR_W-1:0]  ld_waddr;

    logic               size_ok;
    logic               is_idle;
    logic               issue_store;
    logic               issue_load;
    logic [31:0]        ld_shift;
    logic [31:0]        ld_fmt;
    logic               unused_addr_hi;

    // Byte-address bits above the data memory are not decoded.
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    // Alignment per access size; reserved size encodings count as misaligned.
    always_comb begin
        size_ok = 1'b0;
        case (funct3)
            3'b000, 3'b100: size_ok = 1'b1;
            3'b001, 3'b101: size_ok = ~addr[0];
            3'b010:         size_ok = (addr[1:0] == 2'b00);
            default:        size_ok = 1'b0;
        endcase
    end

    // A store beats a simultaneous load; nothing is issued outside IDLE.
    assign is_idle     = (state == IDLE);
    assign issue_store = is_idle & req_write & size_ok;
    assign issue_load  = is_idle & req_read & ~req_write & size_ok;
    assign misaligned  = is_idle & (req_read | req_write) & ~size_ok;
    assign stall       = issue_load | (state == WAIT);
    assign mem_en      = issue_store | issue_load;
    assign mem_addr    = is_idle ? addr[ADDR_W+1:2] : ld_waddr;
    assign state_dbg   = state;

    // Store lane enables and lane-replicated store data.
    always_comb begin
        mem_we    = 4'b0000;
        mem_wdata = wdata;
        case (funct3[1:0])
            2'b00:   mem_wdata = {4{wdata[7:0]}};
            2'b01:   mem_wdata = {2{wdata[15:0]}};
            default: mem_wdata = wdata;
        endcase
        if (issue_store) begin
            case (funct3[1:0])
                2'b00:   mem_we = 4'b0001 << addr[1:0];
                2'b01:   mem_we = addr[1] ? 4'b1100 : 4'b0011;
                default: mem_we = 4'b1111;
            endcase
        end
    end

    // Align the returned word to the latched lane and extend per latched size.
    always_comb begin
        ld_shift = mem_rdata >> {ld_lane, 3'b000};
        case (ld_f3)
            3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_fmt = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_fmt = {24'd0, ld_shift[7:0]};
            3'b101:  ld_fmt = {16'd0, ld_shift[15:0]};
            default: ld_fmt = ld_shift;
        endcase
    end

    // Load sequencing: issue in IDLE, count latency in WAIT, present in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= 3'd0;
            rdata    <= 32'd0;
            ld_f3    <= 3'd0;
            ld_lane  <= 2'd0;
            ld_waddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_load) begin
                        ld_f3    <= funct3;
                        ld_lane  <= addr[1:0];
                        ld_waddr <= addr[ADDR_W+1:2];
                        lat_cnt  <= 3'd1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT) begin
                        rdata <= ld_fmt;
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                DONE: begin
                    lat_cnt <= 3'd0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
